// File: rtl/updown_tick_counter_pkg.sv
// Shared FSM encoding for the up/down tick counter.
// Bit 0 = counting down, bit 1 = paused, so a button press is an XOR.
package updown_tick_counter_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_UP         = 2'b00,
    ST_DOWN       = 2'b01,
    ST_PAUSE_UP   = 2'b10,
    ST_PAUSE_DOWN = 2'b11
  } state_t;

  // Apply both toggles at once; simultaneous presses compose naturally.
  function automatic state_t fsm_next(input state_t s, input logic dir_p,
                                      input logic pause_p);
    return state_t'(s ^ {pause_p, dir_p});
  endfunction

endpackage

// File: rtl/updown_tick_counter_if.sv
// Bundle of tick/button inputs and counter outputs.
interface updown_tick_counter_if #(
  parameter int WIDTH = 4
);
  logic             tick_in;
  logic             dir_btn;
  logic             pause_btn;
  logic [WIDTH-1:0] count;
  logic             dir_up;
  logic             running;
  logic             wrap;

  modport master (
    output tick_in, dir_btn, pause_btn,
    input  count, dir_up, running, wrap
  );

  modport slave (
    input  tick_in, dir_btn, pause_btn,
    output count, dir_up, running, wrap
  );
endinterface

// File: rtl/updown_tick_counter_button_debouncer.sv
// Raw button -> 2-flop sync -> counter debounce -> rising-edge press.
// press is asserted in the cycle whose closing edge flips the debounced
// level high, so consumers act on the same edge the level is accepted.
module button_debouncer #(
  parameter int DEBOUNCE_COUNT = 120000,
  parameter int DB_WIDTH       = 17
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic press
);
  localparam logic [DB_WIDTH-1:0] LP_LAST = DB_WIDTH'(DEBOUNCE_COUNT - 1);

  logic                r_sync1;
  logic                r_sync2;
  logic                r_level;
  logic [DB_WIDTH-1:0] r_cnt;
  logic                w_differ;
  logic                w_flip;

  assign w_differ = r_sync2 ^ r_level;
  assign w_flip   = w_differ && (r_cnt == LP_LAST);
  assign level    = r_level;
  assign press    = w_flip & r_sync2;

  // Synchronizer and debounce counter; any matching cycle restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
      if (w_flip) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else if (w_differ) begin
        r_cnt   <= r_cnt + DB_WIDTH'(1);
      end else begin
        r_cnt   <= '0;
      end
    end
  end
endmodule

// File: rtl/updown_tick_counter.sv
// Up/down LED counter advanced by rising edges of a divided-clock level.
// Two debounced buttons toggle direction and pause via a 4-state FSM.
module updown_tick_counter
  import updown_tick_counter_pkg::*;
#(
  parameter int WIDTH          = 4,
  parameter int DEBOUNCE_COUNT = 120000,
  parameter int DB_WIDTH       = 17
) (
  input  logic                   clk,
  input  logic                   rst,
  updown_tick_counter_if.slave   bus
);
  logic             r_tick_prev;
  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic             r_dir_up;
  logic             r_running;
  logic             r_wrap;

  logic             w_tick;
  logic             w_dir_press;
  logic             w_pause_press;
  logic             w_dir_lvl_unused;
  logic             w_pause_lvl_unused;
  state_t           w_next_state;

  button_debouncer #(
    .DEBOUNCE_COUNT (DEBOUNCE_COUNT),
    .DB_WIDTH       (DB_WIDTH)
  ) u_dir_db (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (bus.dir_btn),
    .level   (w_dir_lvl_unused),
    .press   (w_dir_press)
  );

  button_debouncer #(
    .DEBOUNCE_COUNT (DEBOUNCE_COUNT),
    .DB_WIDTH       (DB_WIDTH)
  ) u_pause_db (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (bus.pause_btn),
    .level   (w_pause_lvl_unused),
    .press   (w_pause_press)
  );

  // tick_prev resets high so a level already high at release is not a tick.
  assign w_tick       = bus.tick_in & ~r_tick_prev;
  assign w_next_state = fsm_next(r_state, w_dir_press, w_pause_press);

  // FSM with outputs decoded from the next state so they move with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_UP;
      r_dir_up  <= 1'b1;
      r_running <= 1'b1;
    end else begin
      r_state   <= w_next_state;
      r_dir_up  <= (w_next_state == ST_UP)   || (w_next_state == ST_PAUSE_UP);
      r_running <= (w_next_state == ST_UP)   || (w_next_state == ST_DOWN);
    end
  end

  // Counter steps on a tick using the pre-edge state; wrap is a 1-cycle pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tick_prev <= 1'b1;
      r_count     <= '0;
      r_wrap      <= 1'b0;
    end else begin
      r_tick_prev <= bus.tick_in;
      r_wrap      <= 1'b0;
      if (w_tick) begin
        case (r_state)
          ST_UP: begin
            r_count <= r_count + WIDTH'(1);
            r_wrap  <= (r_count == '1);
          end
          ST_DOWN: begin
            r_count <= r_count - WIDTH'(1);
            r_wrap  <= (r_count == '0);
          end
          default: r_count <= r_count;
        endcase
      end
    end
  end

  assign bus.count   = r_count;
  assign bus.dir_up  = r_dir_up;
  assign bus.running = r_running;
  assign bus.wrap    = r_wrap;
endmodule

// File: tb/tb_updown_tick_counter.sv
// Directed bench for updown_tick_counter with a small tick scoreboard.
module tb_updown_tick_counter;
  localparam int W   = 4;
  localparam int DC  = 4;
  localparam int DBW = 3;

  typedef struct {
    logic [W-1:0] cnt;
    logic         wr;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks;
  int   failures;
  exp_t sb[$];

  always #5 clk = ~clk;

  updown_tick_counter_if #(.WIDTH(W)) bus();

  updown_tick_counter #(
    .WIDTH          (W),
    .DEBOUNCE_COUNT (DC),
    .DB_WIDTH       (DBW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pop the oldest expectation and compare it with the DUT output.
  task automatic sb_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_count"}, 32'(bus.count), 32'(e.cnt));
      chk({tag, "_wrap"},  32'(bus.wrap),  32'(e.wr));
    end
  endtask

  // One tick_in pulse: rise, check step one cycle later, then fall.
  task automatic tick(input logic [W-1:0] c, input logic w);
    exp_t e;
    e.cnt = c;
    e.wr  = w;
    bus.tick_in = 1'b1;
    sb.push_back(e);
    step();
    sb_check("tick");
    bus.tick_in = 1'b0;
    step();
    chk("wrap_one_cycle", 32'(bus.wrap), 32'd0);
    chk("count_hold_fall", 32'(bus.count), 32'(c));
  endtask

  initial begin
    logic [W-1:0] e;
    logic         w;
    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    bus.tick_in   = 1'b1;
    bus.dir_btn   = 1'b0;
    bus.pause_btn = 1'b0;
    step(2);
    chk("rst_count",   32'(bus.count),   32'd0);
    chk("rst_wrap",    32'(bus.wrap),    32'd0);
    chk("rst_dir_up",  32'(bus.dir_up),  32'd1);
    chk("rst_running", 32'(bus.running), 32'd1);

    // tick_in already high at release must not count
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_high_count", 32'(bus.count), 32'd0);
      chk("hold_high_wrap",  32'(bus.wrap),  32'd0);
    end
    chk("hold_high_dir_up",  32'(bus.dir_up),  32'd1);
    chk("hold_high_running", 32'(bus.running), 32'd1);
    bus.tick_in = 1'b0;
    step();

    // full up sweep with wrap on 15->0
    for (int i = 1; i <= 16; i++) tick(W'(i), i == 16);

    // bouncing dir button, then held
    bus.dir_btn = 1'b1; step();
    bus.dir_btn = 1'b0; step();
    bus.dir_btn = 1'b1; step();
    bus.dir_btn = 1'b0; step();
    chk("bounce_dir_up", 32'(bus.dir_up), 32'd1);
    bus.dir_btn = 1'b1;
    for (int k = 1; k <= DC + 1; k++) begin
      step();
      chk("db_early_dir_up", 32'(bus.dir_up), 32'd1);
    end
    step();
    chk("db_accept_dir_up", 32'(bus.dir_up), 32'd0);
    bus.dir_btn = 1'b0;
    step(DC + 4);
    chk("release_no_event", 32'(bus.dir_up), 32'd0);
    tick(4'd15, 1'b1);

    // pause: count frozen
    bus.pause_btn = 1'b1;
    step(DC + 2);
    chk("pause_running", 32'(bus.running), 32'd0);
    chk("pause_dir_up",  32'(bus.dir_up),  32'd0);
    bus.pause_btn = 1'b0;
    step(DC + 4);
    repeat (3) tick(4'd15, 1'b0);

    // resume, one step down
    bus.pause_btn = 1'b1;
    step(DC + 2);
    chk("resume_running", 32'(bus.running), 32'd1);
    bus.pause_btn = 1'b0;
    step(DC + 4);
    tick(4'd14, 1'b0);

    // back to UP and climb to 5
    bus.dir_btn = 1'b1;
    step(DC + 2);
    chk("redir_dir_up", 32'(bus.dir_up), 32'd1);
    bus.dir_btn = 1'b0;
    step(DC + 4);
    tick(4'd15, 1'b0);
    tick(4'd0, 1'b1);
    for (int c = 1; c <= 5; c++) tick(W'(c), 1'b0);

    // both presses coincide with a tick: old state steps, new state after
    bus.dir_btn   = 1'b1;
    bus.pause_btn = 1'b1;
    step(DC + 1);
    chk("pre_coinc_running", 32'(bus.running), 32'd1);
    bus.tick_in = 1'b1;
    sb.push_back('{cnt: 4'd6, wr: 1'b0});
    step();
    sb_check("coinc");
    chk("coinc_dir_up",  32'(bus.dir_up),  32'd0);
    chk("coinc_running", 32'(bus.running), 32'd0);
    bus.tick_in   = 1'b0;
    bus.dir_btn   = 1'b0;
    bus.pause_btn = 1'b0;
    step(DC + 4);
    tick(4'd6, 1'b0);

    // unpause into DOWN and count down to 9 through a wrap
    bus.pause_btn = 1'b1;
    step(DC + 2);
    chk("down_running", 32'(bus.running), 32'd1);
    chk("down_dir_up",  32'(bus.dir_up),  32'd0);
    bus.pause_btn = 1'b0;
    step(DC + 4);
    e = 4'd6;
    for (int i = 0; i < 13; i++) begin
      w = (e == 4'd0);
      e = e - 4'd1;
      tick(e, w);
    end
    chk("pre_rst_count", 32'(bus.count), 32'd9);

    // reset during a debounce in progress
    bus.dir_btn = 1'b1;
    step(3);
    rst = 1'b1;
    step();
    chk("mid_rst_count",   32'(bus.count),   32'd0);
    chk("mid_rst_dir_up",  32'(bus.dir_up),  32'd1);
    chk("mid_rst_running", 32'(bus.running), 32'd1);
    chk("mid_rst_wrap",    32'(bus.wrap),    32'd0);
    rst = 1'b0;
    for (int k = 1; k <= DC + 1; k++) begin
      step();
      chk("rst_discard_dir_up", 32'(bus.dir_up), 32'd1);
    end
    step();
    chk("rst_rebounce_dir_up", 32'(bus.dir_up), 32'd0);
    chk("rst_rebounce_count",  32'(bus.count),  32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/updown_tick_counter.md
Name: updown_tick_counter

Overview:
Consumes the square-wave output of the clock divider, which is a level toggling at a divided rate in the clk domain, and uses each rising edge as a count tick. Holds a WIDTH-bit up/down counter that drives the board LEDs. Two raw push-buttons are debounced internally: one toggles count direction, the other toggles pause/run. A small FSM owns the direction and run state.

Parameters:
WIDTH, 4, counter bit width (>=2)
DEBOUNCE_COUNT, 120000, consecutive clk cycles a synced button level must differ from the debounced level before it is accepted (>=2)
DB_WIDTH, 17, debounce counter width; must hold DEBOUNCE_COUNT

Ports:
clk  in  1  system clock; sole clock
rst  in  1  synchronous, active-high reset
tick_in  in  1  divided-clock level from the clock divider, same clk domain
dir_btn  in  1  raw active-high button, asynchronous; a press toggles direction
pause_btn  in  1  raw active-high button, asynchronous; a press toggles pause/run
count  out  WIDTH  current counter value, registered
dir_up  out  1  1 = counting up, 0 = counting down, registered
running  out  1  1 = ticks advance the count, registered
wrap  out  1  one-cycle pulse, registered, asserted when the count wraps

Behaviour:
- Only one clock. Every register resets synchronously when rst=1 at a clk rising edge. rst has priority over all other inputs.
- Reset values: count=0, state=UP, dir_up=1, running=1, wrap=0, both debounced levels=0, debounce counters=0, button sync flops=0, tick_prev=1.
- tick_prev resets to 1, so a tick_in that is already high at reset release does not produce a tick.
- Tick detection: tick_prev <= tick_in every cycle. tick = tick_in & ~tick_prev (combinational). tick_in is in the clk domain and is not synchronized.
- Tick latency: count changes at the same clk edge that first samples tick_in=1, so the new value is visible 1 cycle after tick_in rises. Falling edges of tick_in are ignored.
- Button path, per button:
  - 2-flop synchronizer.
  - Debounce counter: increments while the synced level differs from the debounced level, and clears to 0 in any cycle where they match.
  - When the counter reaches DEBOUNCE_COUNT-1 while still differing, the debounced level flips and the counter clears. The new level is accepted after DEBOUNCE_COUNT differing cycles.
  - press = debounced rising edge, a one-cycle pulse. Release generates no event.
- FSM states (encodings in shared header): UP, DOWN, PAUSE_UP, PAUSE_DOWN.
  - dir_btn press: UP<->DOWN, PAUSE_UP<->PAUSE_DOWN.
  - pause_btn press: UP<->PAUSE_UP, DOWN<->PAUSE_DOWN.
  - Both presses in the same cycle apply both toggles, e.g. UP->PAUSE_DOWN.
  - dir_up and running are registered decodes of the next state, so they update with the state.
- Counting on tick, using the state registered before this edge:
  - UP: count+1. At 2^WIDTH-1, wraps to 0 and pulses wrap.
  - DOWN: count-1. At 0, wraps to 2^WIDTH-1 and pulses wrap.
  - PAUSE_*: count holds, wrap=0.
- Tick coincident with a button press: the step uses the old state; the new state applies from the next tick.
- wrap is high for exactly the cycle after the wrapping edge, otherwise 0.
- Arithmetic is modulo 2^WIDTH with no saturation.
- Reset mid-debounce or mid-count abandons all progress. A button held through reset is re-debounced from 0 and produces a press after DEBOUNCE_COUNT+2 cycles.

Decomposition:
- Shared Verilog header (updown_defs.vh): FSM state localparams (2-bit) and the STATE_W width constant.
- One sub-module, button_debouncer: params DEBOUNCE_COUNT and DB_WIDTH; ports clk, rst, btn_raw, level, press. It contains the synchronizer, debounce counter and edge detect, and is instantiated twice.
- Tick edge detect, FSM and counter live in the top module.

Test Plan:
- Reset release with tick_in=1, then tick_in held high for 5 cycles -> count stays 0, wrap=0, dir_up=1, running=1.
- WIDTH=4, 16 tick_in rising edges in UP -> count steps 1..15, then 0. wrap pulses for exactly 1 cycle on the 15->0 step. Each step appears 1 cycle after its tick_in rise.
- DEBOUNCE_COUNT=4, dir_btn bouncing 1-0-1-0 at 1-cycle intervals, then held high -> no toggle during the bounce. dir_up goes to 0 exactly 2 sync + 4 stable cycles after the final rise. Next tick from count=0 gives 15 with a wrap pulse.
- pause_btn press, then 3 ticks -> count frozen, running=0, no wrap. A second press followed by 1 tick -> count advances by 1 in the current direction.
- dir_btn and pause_btn presses land in the same cycle as a tick while in UP at count=5 -> count becomes 6 (old state), state becomes PAUSE_DOWN, and the next tick leaves count at 6.
- rst asserted mid-count at count=9 in DOWN with a debounce in progress -> next cycle count=0, dir_up=1, running=1, wrap=0, and the pending press is discarded.
